// File: rtl/truth_table_scanner.sv
// truth_table_scanner
//   Walks every input combination of a combinational function under test,
//   holds each one for SETTLE cycles, samples the one-bit response into a
//   truth table, then streams the minterm row numbers (rows where F=1) in
//   ascending order over a valid/ready interface.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a scan (only looked at in IDLE)
//   stim           out  N_IN-bit input vector to the function under test
//   resp           in   function output F
//   busy           out  scan in progress (high through the DONE cycle)
//   done           out  one-cycle end-of-scan pulse
//   truth_table    out  bit i = sampled resp for stim == i
//   minterm_count  out  number of ones in truth_table
//   mt_valid       out  mt_index carries a minterm
//   mt_ready       in   consumer accepts mt_index
//   mt_index       out  minterm row number
//   dbg_state      out  current FSM state (IDLE=0, DRIVE=1, EMIT=2, DONE=3)
//
// Handshake: a minterm transfers on a rising edge where mt_valid and
// mt_ready are both 1. Once mt_valid rises it stays high, with mt_index
// unchanged, until that transfer happens; mt_valid does not wait for
// mt_ready.
module truth_table_scanner #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic [N_IN-1:0]        stim,
   input  logic                   resp,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   truth_table,
   output logic [N_IN:0]          minterm_count,
   output logic                   mt_valid,
   input  logic                   mt_ready,
   output logic [N_IN-1:0]        mt_index,
   output logic [1:0]             dbg_state
);

   localparam int ROWS = 1 << N_IN;
   localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_EMIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   stim_q, stim_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ROWS-1:0]   tbl_q, tbl_d;
   logic [N_IN:0]     mc_q, mc_d;
   logic [N_IN-1:0]   ptr_q, ptr_d;

   logic              settle_last;
   logic              stim_last;
   logic              ptr_last;
   logic              row_is_one;

   assign settle_last = (cnt_q == CW'(SETTLE - 1));
   assign stim_last   = (stim_q == {N_IN{1'b1}});
   assign ptr_last    = (ptr_q == {N_IN{1'b1}});
   assign row_is_one  = tbl_q[ptr_q];

   always_comb begin
      state_d = state_q;
      stim_d  = stim_q;
      cnt_d   = cnt_q;
      tbl_d   = tbl_q;
      mc_d    = mc_q;
      ptr_d   = ptr_q;

      case (state_q)
         S_IDLE: begin
            stim_d = '0;
            if (start) begin
               state_d = S_DRIVE;
               cnt_d   = '0;
               tbl_d   = '0;
               mc_d    = '0;
            end
         end

         S_DRIVE: begin
            if (settle_last) begin
               tbl_d[stim_q] = resp;
               if (resp) begin
                  mc_d = mc_q + (N_IN + 1)'(1);
               end
               cnt_d = '0;
               if (stim_last) begin
                  // Capture complete: stimulus returns to zero while emitting.
                  state_d = S_EMIT;
                  stim_d  = '0;
                  ptr_d   = '0;
               end else begin
                  stim_d = stim_q + N_IN'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_EMIT: begin
            // Zero rows are skipped in one cycle; one rows wait for the consumer.
            if (!row_is_one || mt_ready) begin
               if (ptr_last) begin
                  state_d = S_DONE;
               end else begin
                  ptr_d = ptr_q + N_IN'(1);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         stim_q  <= '0;
         cnt_q   <= '0;
         tbl_q   <= '0;
         mc_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         cnt_q   <= cnt_d;
         tbl_q   <= tbl_d;
         mc_q    <= mc_d;
         ptr_q   <= ptr_d;
      end
   end

   assign stim          = stim_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign truth_table   = tbl_q;
   assign minterm_count = mc_q;
   assign mt_valid      = (state_q == S_EMIT) && row_is_one;
   assign mt_index      = mt_valid ? ptr_q : '0;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner. Instance u_a is the 2-input,
// SETTLE=2 configuration; u_b is 3-input, SETTLE=1. sel chooses which
// instance the shared scan task drives and observes.
module tb_truth_table_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start_r;
   logic ready_r;
   int   sel;
   int   a_mode;

   logic       a_start, a_resp, a_busy, a_done, a_valid, a_ready;
   logic [1:0] a_stim, a_index, a_dbg;
   logic [3:0] a_table;
   logic [2:0] a_count;

   logic       b_start, b_resp, b_busy, b_done, b_valid, b_ready;
   logic [2:0] b_stim, b_index;
   logic [1:0] b_dbg;
   logic [7:0] b_table;
   logic [3:0] b_count;

   // Functions under test: a_mode 0 = constant 0, 1 = XOR; u_b sees 3-input AND.
   assign a_resp = (a_mode == 1) ? (a_stim[1] ^ a_stim[0]) : 1'b0;
   assign b_resp = &b_stim;

   assign a_start = (sel == 0) ? start_r : 1'b0;
   assign b_start = (sel == 1) ? start_r : 1'b0;
   assign a_ready = (sel == 0) ? ready_r : 1'b1;
   assign b_ready = (sel == 1) ? ready_r : 1'b1;

   logic       m_valid, m_done, m_busy;
   logic [2:0] m_index, m_stim;
   assign m_valid = (sel == 1) ? b_valid : a_valid;
   assign m_done  = (sel == 1) ? b_done  : a_done;
   assign m_busy  = (sel == 1) ? b_busy  : a_busy;
   assign m_index = (sel == 1) ? b_index : {1'b0, a_index};
   assign m_stim  = (sel == 1) ? b_stim  : {1'b0, a_stim};

   truth_table_scanner #(.N_IN(2), .SETTLE(2)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .stim(a_stim), .resp(a_resp),
      .busy(a_busy), .done(a_done), .truth_table(a_table), .minterm_count(a_count),
      .mt_valid(a_valid), .mt_ready(a_ready), .mt_index(a_index), .dbg_state(a_dbg)
   );

   truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .stim(b_stim), .resp(b_resp),
      .busy(b_busy), .done(b_done), .truth_table(b_table), .minterm_count(b_count),
      .mt_valid(b_valid), .mt_ready(b_ready), .mt_index(b_index), .dbg_state(b_dbg)
   );

   int errors = 0;
   int checks = 0;

   logic [2:0] got_q[$];
   int         done_cyc;
   int         valid_cycles;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one scan on the selected instance. bp: cycles of mt_ready low once
   // the first minterm is offered. inject: pulse start while busy (cycle 5)
   // and during the DONE cycle.
   task automatic run_scan(input int bp, input bit inject);
      int  c;
      int  bp_left;
      bit  stalling;
      int  settle;
      int  rows;
      settle = (sel == 1) ? 1 : 2;
      rows   = (sel == 1) ? 8 : 4;
      got_q.delete();
      valid_cycles = 0;
      done_cyc     = 0;
      bp_left      = bp;
      stalling     = 1'b0;
      @(negedge clk);
      start_r = 1'b1;
      ready_r = 1'b1;
      @(posedge clk);
      c = 1;
      while (c < 200) begin
         @(negedge clk);
         start_r = inject && (c == 5);
         if (inject && c == 5) check("busy_at_inject", {31'd0, m_busy}, 32'd1);
         if (c <= rows * settle) check("stim_seq", {29'd0, m_stim}, (c - 1) / settle);
         if (m_valid) valid_cycles++;
         if (bp_left > 0 && (m_valid || stalling)) begin
            stalling = 1'b1;
            check("stall_valid", {31'd0, m_valid}, 32'd1);
            check("stall_index", {29'd0, m_index}, 32'd1);
            ready_r = 1'b0;
            bp_left--;
         end else begin
            ready_r = 1'b1;
            if (m_valid) got_q.push_back(m_index);
         end
         if (m_done) begin
            done_cyc = c;
            if (inject) start_r = 1'b1;
            break;
         end
         @(posedge clk);
         c++;
      end
      check("done_seen", {31'd0, (done_cyc != 0)}, 32'd1);
      @(negedge clk);
      start_r = 1'b0;
      ready_r = 1'b1;
      check("busy_after", {31'd0, m_busy}, 32'd0);
      check("done_after", {31'd0, m_done}, 32'd0);
      check("stim_after", {29'd0, m_stim}, 32'd0);
   endtask

   task automatic check_xor_result(input int exp_done);
      check("xor_table", {28'd0, a_table}, 32'h6);
      check("xor_count", {29'd0, a_count}, 32'd2);
      check("xor_n_mt", got_q.size(), 32'd2);
      if (got_q.size() == 2) begin
         check("xor_mt0", {29'd0, got_q[0]}, 32'd1);
         check("xor_mt1", {29'd0, got_q[1]}, 32'd2);
      end
      check("xor_done_cyc", done_cyc, exp_done);
   endtask

   initial begin
      rst_n   = 1'b0;
      start_r = 1'b0;
      ready_r = 1'b1;
      sel     = 0;
      a_mode  = 1;
      #1;
      check("rst_stim",  {30'd0, a_stim}, 32'd0);
      check("rst_busy",  {31'd0, a_busy}, 32'd0);
      check("rst_done",  {31'd0, a_done}, 32'd0);
      check("rst_table", {28'd0, a_table}, 32'd0);
      check("rst_count", {29'd0, a_count}, 32'd0);
      check("rst_valid", {31'd0, a_valid}, 32'd0);
      check("rst_index", {30'd0, a_index}, 32'd0);
      check("rst_state", {30'd0, a_dbg}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: XOR, ready held high.
      run_scan(0, 1'b0);
      check_xor_result(13);

      // 2: constant 0.
      a_mode = 0;
      run_scan(0, 1'b0);
      check("zero_table", {28'd0, a_table}, 32'd0);
      check("zero_count", {29'd0, a_count}, 32'd0);
      check("zero_valid_cycles", valid_cycles, 32'd0);
      check("zero_done_cyc", done_cyc, 32'd13);

      // 3: XOR with 5 cycles of backpressure on the first minterm.
      a_mode = 1;
      run_scan(5, 1'b0);
      check_xor_result(18);

      // 4: 3-input AND on the N_IN=3, SETTLE=1 instance.
      sel = 1;
      run_scan(0, 1'b0);
      check("and_table", {24'd0, b_table}, 32'h80);
      check("and_count", {28'd0, b_count}, 32'd1);
      check("and_n_mt", got_q.size(), 32'd1);
      if (got_q.size() == 1) check("and_mt0", {29'd0, got_q[0]}, 32'd7);
      check("and_done_cyc", done_cyc, 32'd17);

      // 5: asynchronous reset while driving stim=2.
      sel = 0;
      @(negedge clk);
      start_r = 1'b1;
      @(posedge clk);
      #1 start_r = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (a_stim == 2'd2) break;
      end
      check("reached_stim2", {30'd0, a_stim}, 32'd2);
      check("partial_table", {28'd0, a_table}, 32'h2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_stim",  {30'd0, a_stim}, 32'd0);
      check("mid_rst_busy",  {31'd0, a_busy}, 32'd0);
      check("mid_rst_table", {28'd0, a_table}, 32'd0);
      check("mid_rst_count", {29'd0, a_count}, 32'd0);
      check("mid_rst_valid", {31'd0, a_valid}, 32'd0);
      check("mid_rst_state", {30'd0, a_dbg}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_scan(0, 1'b0);
      check_xor_result(13);

      // 6: start pulses while busy and in the DONE cycle are ignored.
      run_scan(0, 1'b1);
      check_xor_result(13);
      check("idle_after_inject", {30'd0, a_dbg}, 32'd0);
      run_scan(0, 1'b0);
      check_xor_result(13);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
